mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Byte-serial memory controller between the IF/MEM pipeline stages and the 8-bit unified RAM port.
- Arbitrates instruction fetches against data loads/stores, sequences multi-byte accesses one byte per cycle, and assembles or splits little-endian words.
- Drives the stall controller:
  - mem_stall_req feeds its mem_req input.
  - stall_release feeds its stop_stall input.

Parameters:
ADDR_W, 32, byte-address width on all address ports
DATA_W, 32, pipeline-side data word width (4 bytes)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
if_req  input  1  IF stage requests a 4-byte instruction fetch
if_addr  input  ADDR_W  fetch address
if_flush  input  1  branch flush; abort any IF transaction in progress
if_data  output  DATA_W  fetched instruction, valid when if_done=1
if_done  output  1  one-cycle pulse, fetch complete
mem_req_i  input  1  MEM stage requests a load/store
mem_we  input  1  1 = store, 0 = load
mem_addr  input  ADDR_W  data address
mem_len  input  2  bytes minus one: 0 = 1B, 1 = 2B, 3 = 4B (2 illegal, treated as 4B)
mem_wdata  input  DATA_W  store data, low bytes used
mem_rdata  output  DATA_W  load data, zero-extended, valid when mem_done=1
mem_done  output  1  one-cycle pulse, load/store complete
mem_stall_req  output  1  request to stall controller; freezes front stages
stall_release  output  1  one-cycle pulse to stall controller stop_stall
ram_a  output  ADDR_W  RAM byte address
ram_dout  output  8  RAM write byte
ram_din  input  8  RAM read byte, valid one cycle after ram_a
ram_wr  output  1  RAM write enable

Behaviour:
- Reset (asynchronous, rst=1): all outputs 0, state IDLE, byte counter 0, assembly buffers cleared. Reset mid-transfer aborts it; no done pulse is produced.
- States: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
- IDLE arbitration, evaluated each cycle:
  - mem_req_i=1: go to MEM_RD or MEM_WR by mem_we; latch addr, len, wdata.
  - Otherwise, if_req=1 and if_flush=0: go to IF_RD; latch if_addr.
  - Simultaneous IF and MEM requests: MEM wins. IF stays pending and is served once IDLE is re-entered.
- Reads (IF_RD, MEM_RD), n = number of bytes:
  - Cycle k (k = 0..n-1): ram_a = base+k, ram_wr=0.
  - ram_din sampled at cycle k+1 goes into byte k (little-endian: byte 0 → bits 7:0).
  - After the last byte is captured (cycle n), go to DONE.
  - Latency, accept edge to done pulse: n+1 cycles. IF fetch: 5 cycles.
- MEM_WR:
  - Cycle k: ram_a = base+k, ram_dout = wdata byte k, ram_wr=1.
  - After n cycles go to DONE; latency n cycles.
  - ram_wr is 0 in every other state.
- DONE (one cycle):
  - Pulse if_done or mem_done, with if_data / mem_rdata stable that cycle.
  - For MEM transactions, also pulse stall_release.
  - Return to IDLE.
  - if_data and mem_rdata hold their last value until the next completion.
- mem_stall_req:
  - Asserted combinationally whenever mem_req_i=1 and the controller is not in DONE for a MEM transaction.
  - This includes while IF_RD is finishing (MEM waits behind an active fetch and is never preempted).
  - Deasserted in the DONE cycle of the MEM transaction.
- if_flush:
  - In IF_RD or in DONE-for-IF: return to IDLE next cycle; if_done suppressed.
  - Has no effect on MEM transactions.
- Address arithmetic is base+k modulo 2^ADDR_W; wrap-around is permitted.
- mem_req_i deasserted mid-transaction is ignored; the latched transaction completes.
- No back-to-back overlap: at least one IDLE cycle between transactions.

Test Plan:
- Fetch: RAM[0x100..0x103] = 13,05,10,00; if_req, if_addr=0x100 → ram_a 0x100..0x103 on successive cycles; if_done exactly 5 cycles after accept; if_data=0x00100513.
- Load halfword: RAM[0x2001]=0xAB, RAM[0x2002]=0xCD; mem_req_i, mem_we=0, mem_len=1, addr=0x2001 → mem_rdata=0x0000CDAB; mem_stall_req high until the done cycle; stall_release and mem_done pulse together, one cycle.
- Store word: mem_we=1, mem_len=3, addr=0x40, wdata=0xDEADBEEF → ram_wr high for exactly 4 cycles with (0x40,EF), (0x41,BE), (0x42,AD), (0x43,DE); mem_done on the 5th cycle.
- Contention: if_req and mem_req_i asserted in the same IDLE cycle → MEM is served first; the IF fetch starts after the following IDLE cycle; mem_stall_req is also held while a fetch is in flight and a load arrives mid-fetch.
- Flush: if_flush asserted on the 2nd byte of a fetch → no if_done, controller back to IDLE next cycle, if_data unchanged.
- Reset mid-store after 2 bytes → all outputs 0 immediately (asynchronously); no further ram_wr; after release, a fresh request completes normally.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates IF fetches against MEM loads/stores
// and sequences them one byte per cycle over an 8-bit RAM port, little-endian.
module mem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_data,
    output logic              if_done,
    input  logic              mem_req_i,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_len,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              mem_stall_req,
    output logic              stall_release,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              ram_wr
);
    localparam int NBYTES = DATA_W / 8;

    typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

    state_t            state_reg;
    logic [2:0]        cnt_reg;
    logic [2:0]        last_reg;
    logic              is_mem_reg;
    logic              if_done_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] asm_reg;
    logic [DATA_W-1:0] asm_next;
    logic [DATA_W-1:0] if_data_reg;
    logic [2:0]        len_last;

    // Length code 2 is illegal and is handled as a full word.
    always_comb begin
        len_last = 3'd3;
        case (mem_len)
            2'd0:    len_last = 3'd0;
            2'd1:    len_last = 3'd1;
            default: len_last = 3'd3;
        endcase
    end

    // The byte presented on ram_din in read cycle k belongs to byte lane k-1.
    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_asm
            assign asm_next[gi*8 +: 8] = (cnt_reg == 3'(gi + 1)) ? ram_din : asm_reg[gi*8 +: 8];
        end
    endgenerate

    // A flush landing on the DONE cycle of a fetch must hide the result entirely.
    assign if_done       = if_done_reg & ~if_flush;
    assign if_data       = (state_reg == DONE && !is_mem_reg && !if_flush) ? asm_reg : if_data_reg;
    assign mem_stall_req = mem_req_i & ~rst & ~(state_reg == DONE && is_mem_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            last_reg      <= '0;
            is_mem_reg    <= 1'b0;
            if_done_reg   <= 1'b0;
            wdata_reg     <= '0;
            asm_reg       <= '0;
            if_data_reg   <= '0;
            mem_rdata     <= '0;
            mem_done      <= 1'b0;
            stall_release <= 1'b0;
            ram_a         <= '0;
            ram_dout      <= '0;
            ram_wr        <= 1'b0;
        end else begin
            if_done_reg   <= 1'b0;
            mem_done      <= 1'b0;
            stall_release <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    asm_reg <= '0;
                    if (mem_req_i) begin
                        is_mem_reg <= 1'b1;
                        last_reg   <= len_last;
                        ram_a      <= mem_addr;
                        if (mem_we) begin
                            state_reg <= MEM_WR;
                            ram_wr    <= 1'b1;
                            ram_dout  <= mem_wdata[7:0];
                            wdata_reg <= mem_wdata >> 8;
                        end else begin
                            state_reg <= MEM_RD;
                        end
                    end else if (if_req && !if_flush) begin
                        is_mem_reg <= 1'b0;
                        last_reg   <= 3'(NBYTES - 1);
                        ram_a      <= if_addr;
                        state_reg  <= IF_RD;
                    end
                end
                IF_RD, MEM_RD: begin
                    asm_reg <= asm_next;
                    cnt_reg <= cnt_reg + 3'd1;
                    ram_a   <= ram_a + 1'b1;
                    if (state_reg == IF_RD && if_flush) begin
                        state_reg <= IDLE;
                    end else if (cnt_reg == last_reg + 3'd1) begin
                        state_reg <= DONE;
                        if (state_reg == IF_RD) begin
                            if_done_reg <= 1'b1;
                        end else begin
                            mem_done      <= 1'b1;
                            stall_release <= 1'b1;
                            mem_rdata     <= asm_next;
                        end
                    end
                end
                MEM_WR: begin
                    if (cnt_reg == last_reg) begin
                        state_reg     <= DONE;
                        ram_wr        <= 1'b0;
                        mem_done      <= 1'b1;
                        stall_release <= 1'b1;
                    end else begin
                        cnt_reg   <= cnt_reg + 3'd1;
                        ram_a     <= ram_a + 1'b1;
                        ram_dout  <= wdata_reg[7:0];
                        wdata_reg <= wdata_reg >> 8;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    if (!is_mem_reg && !if_flush) begin
                        if_data_reg <= asm_reg;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: byte-addressed RAM model plus per-transaction expectations
// derived from latency, ordering and little-endian packing rules.
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, mem_req_i, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [1:0]  mem_len;
    logic [31:0] if_data, mem_rdata, ram_a;
    logic        if_done, mem_done, mem_stall_req, stall_release, ram_wr;
    logic [7:0]  ram_dout, ram_din;

    int tests = 0;
    int fails = 0;

    logic [7:0] ram [logic [31:0]];

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_data(if_data), .if_done(if_done),
        .mem_req_i(mem_req_i), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_len(mem_len), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_done(mem_done), .mem_stall_req(mem_stall_req),
        .stall_release(stall_release),
        .ram_a(ram_a), .ram_dout(ram_dout), .ram_din(ram_din), .ram_wr(ram_wr)
    );

    function automatic logic [7:0] rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // RAM: one-cycle read latency, write on the clock edge.
    always @(posedge clk) begin
        ram_din <= rd(ram_a);
        if (ram_wr) ram[ram_a] = ram_dout;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_if_data"}, if_data, 0);
        check({tag, "_if_done"}, 32'(if_done), 0);
        check({tag, "_mem_rdata"}, mem_rdata, 0);
        check({tag, "_mem_done"}, 32'(mem_done), 0);
        check({tag, "_stall"}, 32'(mem_stall_req), 0);
        check({tag, "_release"}, 32'(stall_release), 0);
        check({tag, "_ram_a"}, ram_a, 0);
        check({tag, "_ram_dout"}, 32'(ram_dout), 0);
        check({tag, "_ram_wr"}, 32'(ram_wr), 0);
    endtask

    // Called at a negedge with the controller idle; returns at the negedge after completion.
    task automatic run_if(input logic [31:0] a, input int flush_at, input bit raise_mem);
        logic [31:0] exp, old;
        bit done;
        exp = {rd(a + 32'd3), rd(a + 32'd2), rd(a + 32'd1), rd(a)};
        old = if_data;
        if_addr = a;
        if_req  = 1'b1;
        @(posedge clk);
        done = 1'b0;
        for (int c = 0; c < 12 && !done; c++) begin
            @(negedge clk);
            if (c == 0) if_req = 1'b0;
            if (c < 4 && (flush_at < 0 || c <= flush_at)) begin
                check("if_ram_a", ram_a, a + 32'(c));
                check("if_ram_wr", 32'(ram_wr), 0);
            end
            if (raise_mem && c == 1) begin
                mem_req_i = 1'b1; mem_we = 1'b0; mem_addr = 32'h2001; mem_len = 2'd1;
            end
            if (raise_mem && c >= 2) check("stall_mid_fetch", 32'(mem_stall_req), 1);
            if (flush_at >= 0) begin
                if (c == flush_at) if_flush = 1'b1;
                if (c == flush_at + 1) if_flush = 1'b0;
                #1;
                check("flush_no_done", 32'(if_done), 0);
                check("flush_if_data", if_data, old);
                if (c == 8) done = 1'b1;
            end else if (if_done) begin
                done = 1'b1;
                check("if_latency", 32'(c), 5);
                check("if_data", if_data, exp);
            end
        end
        if (!done) check("if_timeout", 0, 1);
        if (flush_at < 0) begin
            @(negedge clk);
            check("if_done_pulse", 32'(if_done), 0);
            check("if_data_hold", if_data, exp);
            if (raise_mem) check("stall_after_fetch", 32'(mem_stall_req), 1);
        end
        $display("[TB] fetch addr=%h data=%h flush_at=%0d", a, if_data, flush_at);
    endtask

    task automatic run_mem(input bit we, input logic [31:0] a, input logic [1:0] len,
                           input logic [31:0] wd, input bit also_if, input int rst_at);
        int n, lastc;
        logic [31:0] exp;
        logic [7:0] keep2;
        bit done;
        n = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
        lastc = we ? n : n + 1;
        exp = 0;
        for (int k = 0; k < n; k++) exp |= 32'(rd(a + 32'(k))) << (8 * k);
        keep2 = rd(a + 32'd2);
        mem_req_i = 1'b1; mem_we = we; mem_addr = a; mem_len = len; mem_wdata = wd;
        if (also_if) begin if_req = 1'b1; if_addr = 32'h100; end
        @(posedge clk);
        done = 1'b0;
        for (int c = 0; c < 12 && !done; c++) begin
            @(negedge clk);
            if (rst_at >= 0 && c == rst_at) begin
                rst = 1'b1;
                #1;
                check_all_zero("rst_mid");
                mem_req_i = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                check("rst_byte1_written", 32'(rd(a + 32'd1)), 32'(wd[15:8]));
                check("rst_byte2_untouched", 32'(rd(a + 32'd2)), 32'(keep2));
                @(negedge clk);
                check("rst_no_done", 32'(mem_done), 0);
                check("rst_no_wr", 32'(ram_wr), 0);
                $display("[TB] store addr=%h aborted by reset", a);
                return;
            end
            if (c < n) begin
                check("mem_ram_a", ram_a, a + 32'(c));
                check("mem_ram_wr", 32'(ram_wr), 32'(we));
                if (we) check("mem_ram_dout", 32'(ram_dout), 32'(wd[8*c +: 8]));
            end else begin
                check("mem_ram_wr_idle", 32'(ram_wr), 0);
            end
            check("mem_stall", 32'(mem_stall_req), (c == lastc) ? 0 : 1);
            check("release_eq_done", 32'(stall_release), 32'(mem_done));
            if (mem_done) begin
                done = 1'b1;
                check("mem_latency", 32'(c), 32'(lastc));
                if (!we) check("mem_rdata", mem_rdata, exp);
                mem_req_i = 1'b0;
            end
        end
        if (!done) check("mem_timeout", 0, 1);
        @(negedge clk);
        check("mem_done_pulse", 32'(mem_done), 0);
        check("release_pulse", 32'(stall_release), 0);
        if (!we) check("mem_rdata_hold", mem_rdata, exp);
        else for (int k = 0; k < n; k++) check("store_ram", 32'(rd(a + 32'(k))), 32'(wd[8*k +: 8]));
        if (also_if) check("if_pending_idle_wr", 32'(ram_wr), 0);
        $display("[TB] %s addr=%h len=%0d data=%h", we ? "store" : "load", a, len, we ? wd : mem_rdata);
    endtask

    initial begin
        rst = 1'b1;
        if_req = 0; if_flush = 0; mem_req_i = 0; mem_we = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0; mem_len = 0;
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h10; ram[32'h103] = 8'h00;
        ram[32'h2001] = 8'hAB; ram[32'h2002] = 8'hCD;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        run_if(32'h100, -1, 1'b0);
        check("fetch_word", if_data, 32'h00100513);
        run_mem(1'b0, 32'h2001, 2'd1, 32'h0, 1'b0, -1);
        check("load_half", mem_rdata, 32'h0000CDAB);
        run_mem(1'b1, 32'h40, 2'd3, 32'hDEADBEEF, 1'b0, -1);
        run_mem(1'b0, 32'h40, 2'd3, 32'h0, 1'b1, -1);
        check("contention_load", mem_rdata, 32'hDEADBEEF);
        run_if(32'h100, -1, 1'b0);
        run_if(32'h2000, -1, 1'b1);
        run_mem(1'b0, 32'h2001, 2'd1, 32'h0, 1'b0, -1);
        run_if(32'h200, 1, 1'b0);
        run_if(32'h100, -1, 1'b0);
        run_mem(1'b1, 32'h50, 2'd3, 32'h11223344, 1'b0, 2);
        run_mem(1'b0, 32'h50, 2'd3, 32'h0, 1'b0, -1);
        run_mem(1'b1, 32'hFFFFFFFE, 2'd3, 32'hCAFEF00D, 1'b0, -1);
        run_mem(1'b0, 32'hFFFFFFFF, 2'd1, 32'h0, 1'b0, -1);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            int kind;
            kind = $urandom_range(0, 2);
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                            : 32'h3000 + 32'($urandom_range(0, 15));
            case (kind)
                0: run_if(a, -1, 1'b0);
                1: run_mem(1'b0, a, 2'($urandom_range(0, 3)), 32'h0, 1'b0, -1);
                default: run_mem(1'b1, a, 2'($urandom_range(0, 3)), $urandom, 1'b0, -1);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
